// File: rtl/serial_gearbox_pkg.sv
// Shared sizing helpers and DVI control-token constants for the serial gearbox.
package serial_gearbox_pkg;

  localparam logic [9:0] DVI_CTRL_TOKEN0 = 10'b1101010100;
  localparam logic [9:0] DVI_CTRL_TOKEN1 = 10'b0010101011;
  localparam logic [9:0] DVI_CTRL_TOKEN2 = 10'b0101010100;
  localparam logic [9:0] DVI_CTRL_TOKEN3 = 10'b1010101011;

  // Residual (< OUT_W) bits plus one whole word.
  function automatic int unsigned buf_w(input int unsigned data_w, input int unsigned out_w);
    return data_w + out_w - 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned data_w, input int unsigned out_w);
    return $clog2(buf_w(data_w, out_w) + 1);
  endfunction

endpackage

// File: rtl/serial_gearbox_lane.sv
// One gearbox lane: residual shift buffer, word merge behind the residue, beat extraction.
module serial_gearbox_lane
  import serial_gearbox_pkg::*;
#(
  parameter  int unsigned DATA_W    = 10,
  parameter  int unsigned OUT_W     = 2,
  parameter  int unsigned LSB_FIRST = 1,
  localparam int unsigned BUF_W     = buf_w(DATA_W, OUT_W),
  localparam int unsigned CNT_W     = cnt_w(DATA_W, OUT_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_emit,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [DATA_W-1:0] i_word,
  output logic [OUT_W-1:0]  o_bits
);

  logic [BUF_W-1:0]  r_buf;
  logic [OUT_W-1:0]  r_bits;
  logic [DATA_W-1:0] w_word;
  logic [BUF_W-1:0]  w_merged;

  // Oldest bit sits at buffer bit 0; a new word lands just above the residue.
  always_comb begin
    w_word = i_word;
    if (LSB_FIRST == 0) begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        w_word[i] = i_word[int'(DATA_W) - 1 - i];
      end
    end
    w_merged = r_buf;
    if (i_load) begin
      w_merged = r_buf | (BUF_W'(w_word) << i_cnt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf  <= '0;
      r_bits <= '0;
    end else if (i_emit) begin
      r_buf  <= w_merged >> OUT_W;
      r_bits <= w_merged[OUT_W-1:0];
    end else begin
      r_buf  <= w_merged;
      r_bits <= '0;
    end
  end

  assign o_bits = r_bits;

endmodule

// File: rtl/serial_gearbox_n_to_m.sv
// NUM_CH-lane DATA_W:OUT_W serialising gearbox with valid/ready input and underflow flag.
// Optional GEARBOX_IDLE_FILL_EN: starved beats are filled with IDLE_WORD instead of stalling.
module serial_gearbox_n_to_m
  import serial_gearbox_pkg::*;
#(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned OUT_W     = 2,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned LSB_FIRST = 1
`ifdef GEARBOX_IDLE_FILL_EN
  ,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DVI_CTRL_TOKEN0)
`endif
) (
  input  logic                     serial_clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [NUM_CH*OUT_W-1:0]  out_data,
  output logic                     underflow
);

  localparam int unsigned CNT_W = cnt_w(DATA_W, OUT_W);

  if (OUT_W > DATA_W || OUT_W < 1 || NUM_CH < 1 || DATA_W < 2) begin : g_bad_cfg
    $error("serial_gearbox_n_to_m: unsupported DATA_W/OUT_W/NUM_CH combination");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             r_out_valid;
  logic             r_underflow;
  logic             w_accept;
  logic             w_inject;
  logic             w_load;
  logic             w_emit;
  logic [CNT_W-1:0] w_merged_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign in_ready = (r_cnt < CNT_W'(OUT_W));

  // Shared fill-count bookkeeping; every lane follows the same load/emit strobes.
  always_comb begin
    w_accept = in_valid & in_ready;
    w_inject = 1'b0;
`ifdef GEARBOX_IDLE_FILL_EN
    w_inject = ~w_accept & in_ready & r_seen;
`endif
    w_load       = w_accept | w_inject;
    w_merged_cnt = w_load ? r_cnt + CNT_W'(DATA_W) : r_cnt;
    w_emit       = (w_merged_cnt >= CNT_W'(OUT_W));
    w_cnt_nxt    = w_emit ? w_merged_cnt - CNT_W'(OUT_W) : w_merged_cnt;
  end

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_seen      <= r_seen | w_accept;
      r_out_valid <= w_emit;
      r_underflow <= r_underflow | (~w_emit & r_seen);
    end
  end

  assign out_valid = r_out_valid;
  assign underflow = r_underflow;

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_lane
    logic [DATA_W-1:0] w_word;
`ifdef GEARBOX_IDLE_FILL_EN
    assign w_word = w_inject ? IDLE_WORD : in_data[c*DATA_W +: DATA_W];
`else
    assign w_word = in_data[c*DATA_W +: DATA_W];
`endif
    serial_gearbox_lane #(
      .DATA_W    (DATA_W),
      .OUT_W     (OUT_W),
      .LSB_FIRST (LSB_FIRST)
    ) u_lane (
      .i_clk   (serial_clk),
      .i_reset (reset),
      .i_load  (w_load),
      .i_emit  (w_emit),
      .i_cnt   (r_cnt),
      .i_word  (w_word),
      .o_bits  (out_data[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_serial_gearbox_n_to_m.sv
// Directed table vectors for 10:2 and 10:4 single-lane gearboxes, plus a bitstream model for 3-lane 8:3 MSB-first.
module tb_serial_gearbox_n_to_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, vld_a, rdy_a, ov_a, uf_a;
  logic [9:0] din_a;
  logic [1:0] dout_a;

  logic       rst_b, vld_b, rdy_b, ov_b, uf_b;
  logic [9:0] din_b;
  logic [3:0] dout_b;

  logic        rst_c, vld_c, rdy_c, ov_c, uf_c;
  logic [23:0] din_c;
  logic [8:0]  dout_c;

  serial_gearbox_n_to_m #(.DATA_W(10), .OUT_W(2), .NUM_CH(1), .LSB_FIRST(1)) dut_a (
    .serial_clk(clk), .reset(rst_a), .in_valid(vld_a), .in_ready(rdy_a), .in_data(din_a),
    .out_valid(ov_a), .out_data(dout_a), .underflow(uf_a));

  serial_gearbox_n_to_m #(.DATA_W(10), .OUT_W(4), .NUM_CH(1), .LSB_FIRST(1)) dut_b (
    .serial_clk(clk), .reset(rst_b), .in_valid(vld_b), .in_ready(rdy_b), .in_data(din_b),
    .out_valid(ov_b), .out_data(dout_b), .underflow(uf_b));

  serial_gearbox_n_to_m #(.DATA_W(8), .OUT_W(3), .NUM_CH(3), .LSB_FIRST(0)) dut_c (
    .serial_clk(clk), .reset(rst_c), .in_valid(vld_c), .in_ready(rdy_c), .in_data(din_c),
    .out_valid(ov_c), .out_data(dout_c), .underflow(uf_c));

  // Drive fields apply to the next rising edge; expect fields are sampled before driving.
  typedef struct {
    logic       rst;
    logic       vld;
    logic [9:0] din;
    logic       rdy;
    logic       ov;
    logic [3:0] dout;
    logic       uf;
  } vec_t;

  vec_t tab_a [33];
  vec_t tab_b [7];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [9:0] din,
                              input logic rdy, input logic ov, input logic [3:0] dout,
                              input logic uf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = din; v.rdy = rdy; v.ov = ov; v.dout = dout; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  bit          q [3][$];
  logic [23:0] word;
  logic        exp_ov;
  logic [8:0]  exp_do;
  logic        exp_rdy;

  initial begin
    // 10:2, one lane: single word, starved stream, reset mid-word
    tab_a[0]  = mk('0, '1, 10'h353, '1, '0, 4'h0, '0);
    tab_a[1]  = mk('0, '0, 10'h000, '0, '1, 4'h3, '0);
    tab_a[2]  = mk('0, '0, 10'h000, '0, '1, 4'h0, '0);
    tab_a[3]  = mk('0, '0, 10'h000, '0, '1, 4'h1, '0);
    tab_a[4]  = mk('0, '0, 10'h000, '0, '1, 4'h1, '0);
    tab_a[5]  = mk('0, '0, 10'h000, '1, '1, 4'h3, '0);
    tab_a[6]  = mk('1, '0, 10'h000, '1, '0, 4'h0, '1);
    tab_a[7]  = mk('0, '1, 10'h3FF, '1, '0, 4'h0, '0);
    tab_a[8]  = mk('0, '1, 10'h3FF, '0, '1, 4'h3, '0);
    tab_a[9]  = mk('0, '1, 10'h3FF, '0, '1, 4'h3, '0);
    tab_a[10] = mk('0, '1, 10'h3FF, '0, '1, 4'h3, '0);
    tab_a[11] = mk('0, '1, 10'h3FF, '0, '1, 4'h3, '0);
    tab_a[12] = mk('0, '0, 10'h000, '1, '1, 4'h3, '0);
    tab_a[13] = mk('0, '0, 10'h000, '1, '0, 4'h0, '1);
    tab_a[14] = mk('0, '0, 10'h000, '1, '0, 4'h0, '1);
    tab_a[15] = mk('0, '1, 10'h001, '1, '0, 4'h0, '1);
    tab_a[16] = mk('0, '0, 10'h000, '0, '1, 4'h1, '1);
    tab_a[17] = mk('0, '0, 10'h000, '0, '1, 4'h0, '1);
    tab_a[18] = mk('0, '0, 10'h000, '0, '1, 4'h0, '1);
    tab_a[19] = mk('0, '0, 10'h000, '0, '1, 4'h0, '1);
    tab_a[20] = mk('0, '0, 10'h000, '1, '1, 4'h0, '1);
    tab_a[21] = mk('1, '0, 10'h000, '1, '0, 4'h0, '1);
    tab_a[22] = mk('0, '1, 10'h353, '1, '0, 4'h0, '0);
    tab_a[23] = mk('0, '0, 10'h000, '0, '1, 4'h3, '0);
    tab_a[24] = mk('0, '0, 10'h000, '0, '1, 4'h0, '0);
    tab_a[25] = mk('1, '0, 10'h000, '0, '1, 4'h1, '0);
    tab_a[26] = mk('0, '1, 10'h0E4, '1, '0, 4'h0, '0);
    tab_a[27] = mk('0, '0, 10'h000, '0, '1, 4'h0, '0);
    tab_a[28] = mk('0, '0, 10'h000, '0, '1, 4'h1, '0);
    tab_a[29] = mk('0, '0, 10'h000, '0, '1, 4'h2, '0);
    tab_a[30] = mk('0, '0, 10'h000, '0, '1, 4'h3, '0);
    tab_a[31] = mk('0, '0, 10'h000, '1, '1, 4'h0, '0);
    tab_a[32] = mk('0, '0, 10'h000, '1, '0, 4'h0, '1);
    // 10:4, one lane: a beat spanning two words
    tab_b[0]  = mk('0, '1, 10'h3FF, '1, '0, 4'h0, '0);
    tab_b[1]  = mk('0, '1, 10'h000, '0, '1, 4'hF, '0);
    tab_b[2]  = mk('0, '1, 10'h000, '1, '1, 4'hF, '0);
    tab_b[3]  = mk('0, '0, 10'h000, '0, '1, 4'h3, '0);
    tab_b[4]  = mk('0, '0, 10'h000, '0, '1, 4'h0, '0);
    tab_b[5]  = mk('0, '0, 10'h000, '1, '1, 4'h0, '0);
    tab_b[6]  = mk('0, '0, 10'h000, '1, '0, 4'h0, '1);

    rst_a = 1'b1; vld_a = 1'b0; din_a = '0;
    rst_b = 1'b1; vld_b = 1'b0; din_b = '0;
    rst_c = 1'b1; vld_c = 1'b0; din_c = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      chk("a_ready", i, 32'(rdy_a),  32'(tab_a[i].rdy));
      chk("a_valid", i, 32'(ov_a),   32'(tab_a[i].ov));
      chk("a_data",  i, 32'(dout_a), 32'(tab_a[i].dout));
      chk("a_uflow", i, 32'(uf_a),   32'(tab_a[i].uf));
      rst_a = tab_a[i].rst; vld_a = tab_a[i].vld; din_a = tab_a[i].din;
    end
    vld_a = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b_ready", i, 32'(rdy_b),  32'(tab_b[i].rdy));
      chk("b_valid", i, 32'(ov_b),   32'(tab_b[i].ov));
      chk("b_data",  i, 32'(dout_b), 32'(tab_b[i].dout));
      chk("b_uflow", i, 32'(uf_b),   32'(tab_b[i].uf));
      rst_b = tab_b[i].rst; vld_b = tab_b[i].vld; din_b = tab_b[i].din;
    end
    vld_b = 1'b0;

    // 8:3, three lanes, MSB first, continuous input against a per-lane bit queue
    word   = 24'($urandom);
    exp_ov = 1'b0;
    exp_do = '0;
    for (int s = 0; s < 1000; s++) begin
      @(negedge clk);
      exp_rdy = (q[0].size() < 3);
      chk("c_ready", s, 32'(rdy_c),  32'(exp_rdy));
      chk("c_valid", s, 32'(ov_c),   32'(exp_ov));
      chk("c_data",  s, 32'(dout_c), 32'(exp_do));
      chk("c_uflow", s, 32'(uf_c),   32'(1'b0));
      vld_c = 1'b1;
      din_c = word;
      if (exp_rdy) begin
        for (int c = 0; c < 3; c++)
          for (int b = 7; b >= 0; b--) q[c].push_back(word[c*8 + b]);
        word = 24'($urandom);
      end
      exp_ov = 1'b0;
      exp_do = '0;
      if (q[0].size() >= 3) begin
        exp_ov = 1'b1;
        for (int c = 0; c < 3; c++)
          for (int k = 0; k < 3; k++) exp_do[c*3 + k] = q[c].pop_front();
      end
    end
    vld_c = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
